// File: rtl/imem_loader.sv
// Byte-stream program loader into a DEPTH-byte instruction memory with a 10-byte combinational fetch window.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: the in_last byte is an 8-bit additive checksum and is not stored.
module imem_loader #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [63:0] fetch_addr,
  output logic [79:0] fetch_bytes,
  output logic        imem_er,
  output logic        run,
  output logic        load_er,
  output logic [11:0] byte_count
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [11:0] FULL = 12'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  state_t      r_state, w_next;
  logic [11:0] r_count;
  logic        r_load_er;
  logic [7:0]  r_mem [DEPTH];

  logic w_accept, w_full, w_store, w_start, w_ck_ok;

  assign w_accept = (r_state == LOAD) && in_valid;
  assign w_full   = (r_count == FULL);
  assign w_start  = load_start && (r_state != LOAD);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  assign w_store = w_accept && !w_full && !in_last;
  assign w_ck_ok = (r_sum == in_data);
`else
  assign w_store = w_accept && !w_full;
  assign w_ck_ok = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RUN, ERR: if (load_start) w_next = LOAD;
      LOAD: begin
        // Overflow wins over in_last: a byte arriving with memory full is an error either way.
        if (w_accept) begin
          if (w_full)       w_next = ERR;
          else if (in_last) w_next = w_ck_ok ? RUN : ERR;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_load_er <= 1'b0;
    end else if (w_start) begin
      r_count   <= '0;
      r_load_er <= 1'b0;
    end else begin
      if (w_store) r_count <= r_count + 12'd1;
      if (r_state == LOAD && w_next == ERR) r_load_er <= 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sum <= '0;
    else if (w_start) r_sum <= '0;
    else if (w_store) r_sum <= r_sum + in_data;
  end
`endif

  // Memory is deliberately not reset; writes only happen in LOAD, which reset leaves.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_count[AW-1:0]] <= in_data;
  end

  assign imem_er = |fetch_addr[63:AW];

  genvar g;
  for (g = 0; g < 10; g++) begin : g_lane
    logic [AW:0] w_idx;
    assign w_idx = {1'b0, fetch_addr[AW-1:0]} + (AW+1)'(g);
    assign fetch_bytes[8*g +: 8] = (imem_er || w_idx[AW]) ? 8'h00 : r_mem[w_idx[AW-1:0]];
  end

  assign in_ready   = (r_state == LOAD);
  assign run        = (r_state == RUN);
  assign load_er    = r_load_er;
  assign byte_count = r_count;
endmodule
